// File: rtl/score_sum_unloader_if.sv
// Streaming output channel of score_sum_unloader: one score word per beat,
// tagged with its bank and address, valid/ready handshake.
interface score_sum_unloader_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PARALLEL   = 8
);
  localparam int unsigned BANK_W = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;

  logic [DATA_WIDTH-1:0] out_data;
  logic [BANK_W-1:0]     out_bank;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output out_data, out_bank, out_addr, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_bank, out_addr, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/score_sum_unloader.sv
// Unloads PARALLEL score_sum BRAM banks address-major, bank-minor onto a stream.
// Define SCORE_SUM_CLEAR_ON_READ_EN to zero each address as it is captured.
module score_sum_unloader #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PARALLEL   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH:0]            num_addr,
  output logic [ADDR_WIDTH*PARALLEL-1:0] mem_addr_score_sum,
  output logic [PARALLEL-1:0]            mem_score_write_sum_en,
  output logic [DATA_WIDTH*PARALLEL-1:0] mem_data_out_score_out_sum,
  input  logic [DATA_WIDTH*PARALLEL-1:0] mem_data_in_score_sum,
  score_sum_unloader_if.master           out,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned BANK_W = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(PARALLEL - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CAPTURE, DRAIN, FINISH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt, last_addr;
  logic [BANK_W-1:0]     bank;
  logic [DATA_WIDTH-1:0] buffer [PARALLEL];
  logic                  xfer, addr_end;

  // Handshake qualified by state rather than out_valid to keep the
  // next-state logic free of a loop through the output.
  assign xfer     = (state == DRAIN) && out.out_ready;
  assign addr_end = (addr_cnt == last_addr);

  assign mem_addr_score_sum = {PARALLEL{addr_cnt}};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    out.out_valid = 1'b0;
    out.out_last  = 1'b0;
    out.out_data  = buffer[bank];
    out.out_bank  = bank;
    out.out_addr  = addr_cnt;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_addr == '0) ? FINISH : READ;
      end
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = DRAIN;
      DRAIN: begin
        out.out_valid = 1'b1;
        out.out_last  = addr_end && (bank == LAST_BANK);
        if (xfer && bank == LAST_BANK) state_nxt = addr_end ? FINISH : READ;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt  <= '0;
      last_addr <= '0;
      bank      <= '0;
      for (int unsigned i = 0; i < PARALLEL; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && num_addr != '0) begin
            addr_cnt <= '0;
            bank     <= '0;
            // Counts beyond the address space saturate to the full range.
            last_addr <= num_addr[ADDR_WIDTH] ? '1
                                              : num_addr[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
          end
        end
        CAPTURE: begin
          for (int unsigned i = 0; i < PARALLEL; i++)
            buffer[i] <= mem_data_in_score_sum[i*DATA_WIDTH +: DATA_WIDTH];
          bank <= '0;
        end
        DRAIN: begin
          if (xfer) begin
            if (bank == LAST_BANK) begin
              bank <= '0;
              if (!addr_end) addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            end else begin
              bank <= bank + BANK_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_SUM_CLEAR_ON_READ_EN
  // High only in the first DRAIN cycle of each address, after its capture.
  logic clr_pend;

  always_ff @(posedge clk) begin
    if (rst) clr_pend <= 1'b0;
    else     clr_pend <= (state == CAPTURE);
  end

  assign mem_score_write_sum_en     = {PARALLEL{clr_pend}};
  assign mem_data_out_score_out_sum = '0;
`else
  assign mem_score_write_sum_en     = '0;
  assign mem_data_out_score_out_sum = '0;
`endif

endmodule

// File: tb/tb_score_sum_unloader.sv
// Directed bench for score_sum_unloader against a read-first BRAM model whose
// banks hold addr*16+bank; honours SCORE_SUM_CLEAR_ON_READ_EN if defined.
module tb_score_sum_unloader;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned P  = 8;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef SCORE_SUM_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_addr = '0;
  logic [AW*P-1:0] mem_addr;
  logic [P-1:0]    mem_we;
  logic [DW*P-1:0] mem_wdata;
  logic [DW*P-1:0] mem_rdata;
  logic          busy, done;
  logic          reinit = 1'b0;

  int checks   = 0;
  int failures = 0;

  score_sum_unloader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLEL(P)) ifc ();

  score_sum_unloader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLEL(P)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .num_addr                   (num_addr),
    .mem_addr_score_sum         (mem_addr),
    .mem_score_write_sum_en     (mem_we),
    .mem_data_out_score_out_sum (mem_wdata),
    .mem_data_in_score_sum      (mem_rdata),
    .out                        (ifc.master),
    .busy                       (busy),
    .done                       (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [P][DEPTH];

  always @(posedge clk) begin
    for (int b = 0; b < int'(P); b++) begin
      if (reinit) begin
        for (int a = 0; a < int'(DEPTH); a++) mem[b][a] <= DW'(a * 16 + b);
      end else if (mem_we[b]) begin
        mem[b][mem_addr[b*AW +: AW]] <= mem_wdata[b*DW +: DW];
      end
      mem_rdata[b*DW +: DW] <= mem[b][mem_addr[b*AW +: AW]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refill();
    @(negedge clk); reinit = 1'b1;
    @(negedge clk); reinit = 1'b0;
  endtask

  // Runs one unload; every word is checked against its address-major index.
  // abort_idx >= 0 asserts reset while that word is pending.
  task automatic run_unload(input int n, input int mode, input bit zero,
                            input bit repulse, input int abort_idx, input string tag);
    int total, cnt, cyc, first_valid, last_xfer;
    bit got_done, prev_valid;
    int ea, eb;
    logic [AW-1:0] ea_l;
    total = ((n > int'(DEPTH)) ? int'(DEPTH) : n) * int'(P);
    cnt = 0; cyc = 0; first_valid = -1; last_xfer = 0;
    got_done = 1'b0; prev_valid = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk); start = 1'b1; num_addr = (AW+1)'(n);
    @(negedge clk); start = 1'b0;
    while (!got_done && cyc < 2000) begin
      cyc++;
      if (done) begin
        got_done = 1'b1;
        chk({tag, "_done_delay"}, 64'(cyc - last_xfer), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        chk({tag, "_valid_at_done"}, 64'(ifc.out_valid), 64'd0);
      end else begin
        if (repulse && cyc == 6) begin start = 1'b1; num_addr = 1; end
        else start = 1'b0;
        if (ifc.out_valid) begin
          if (first_valid < 0) first_valid = cyc;
          ea = cnt / int'(P); eb = cnt % int'(P); ea_l = AW'(ea);
          chk({tag, "_data"}, 64'(ifc.out_data), zero ? 64'd0 : 64'(ea * 16 + eb));
          chk({tag, "_bank"}, 64'(ifc.out_bank), 64'(eb));
          chk({tag, "_addr"}, 64'(ifc.out_addr), 64'(ea));
          chk({tag, "_last"}, 64'(ifc.out_last), 64'(cnt == total - 1));
          chk({tag, "_lanes"}, 64'(mem_addr), 64'({P{ea_l}}));
          chk({tag, "_we"}, 64'(mem_we), (CLR && !prev_valid) ? 64'hFF : 64'd0);
          if (abort_idx >= 0 && cnt == abort_idx) begin
            ifc.out_ready = 1'b0;
            rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            chk({tag, "_valid_after_rst"}, 64'(ifc.out_valid), 64'd0);
            chk({tag, "_busy_after_rst"}, 64'(busy), 64'd0);
            chk({tag, "_addr_after_rst"}, 64'(ifc.out_addr), 64'd0);
            got_done = 1'b0;
            repeat (12) begin
              @(negedge clk);
              if (done) got_done = 1'b1;
            end
            chk({tag, "_no_done"}, 64'(got_done), 64'd0);
            return;
          end
        end else begin
          chk({tag, "_we_idle"}, 64'(mem_we), 64'd0);
        end
        ifc.out_ready = (mode == 0) ? 1'b1 : cyc[0];
        if (ifc.out_valid && ifc.out_ready) begin
          cnt++;
          last_xfer = cyc;
        end
        prev_valid = ifc.out_valid;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
    chk({tag, "_count"}, 64'(cnt), 64'(total));
    chk({tag, "_first_valid"}, 64'(first_valid), (total > 0) ? 64'd4 : 64'hFFFF_FFFF_FFFF_FFFF);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    ifc.out_ready = 1'b1;
    reinit = 1'b1;
    repeat (3) @(negedge clk);
    reinit = 1'b0;
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_last", 64'(ifc.out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(ifc.out_data), 64'd0);
    chk("rst_bank", 64'(ifc.out_bank), 64'd0);
    chk("rst_addr", 64'(ifc.out_addr), 64'd0);
    chk("rst_lanes", 64'(mem_addr), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_unload(2, 0, 1'b0, 1'b0, -1, "basic");
    refill();
    run_unload(3, 1, 1'b0, 1'b0, -1, "stall");
    run_unload(0, 0, 1'b0, 1'b0, -1, "zero");
    refill();
    run_unload(2, 0, 1'b0, 1'b0, 11, "abort");
    refill();
    run_unload(1, 0, 1'b0, 1'b0, -1, "restart");
    refill();
    run_unload(2, 0, 1'b0, 1'b1, -1, "repulse");
    refill();
    run_unload(15, 0, 1'b0, 1'b0, -1, "clamp");
    refill();
    run_unload(4, 0, 1'b0, 1'b0, -1, "first");
    run_unload(4, 0, CLR, 1'b0, -1, "second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
